// File: rtl/seq_gen_10010_pkg.sv
// Shared types and constants for the 10010 serial pattern generator.
// Holds the FSM encoding, default pattern parameters and gap-filler LFSR constants.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int         DEF_PAT_LEN = 5;
  localparam logic [4:0] DEF_PATTERN = 5'b10010;
  localparam int         DEF_OVL_LEN = 2;

  // x^8+x^6+x^5+x^4+1 with a right-shifting register: taps sit at bits 0,2,3,4
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {^(cur & LFSR_TAPS), cur[7:1]};
  endfunction

endpackage

// File: rtl/seq_gen_10010_if.sv
// Request/stream bundle between a pattern-generator client and seq_gen_10010.
// master = client driving start/count/gap; slave = the generator.
interface seq_gen_10010_if;
  logic       start;
  logic [7:0] count;
  logic [3:0] gap;
  logic       data_out;
  logic       data_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, count, gap,
    input  data_out, data_valid, busy, done
  );

  modport slave (
    input  start, count, gap,
    output data_out, data_valid, busy, done
  );
endinterface

// File: rtl/seq_gen_10010_lfsr.sv
// Purpose: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing gap filler bits.
// Latency: bit_o is the register LSB now; the register steps on an edge with en high.
// Backpressure: none; holds its state whenever en is low.
module seq_gen_lfsr
  import seq_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/seq_gen_10010.sv
// Purpose: serial transmitter of PATTERN, count times, with optional filler gap (SEQ_GEN_LFSR_EN = LFSR filler).
// Latency: first pattern bit is on data_out the cycle after start is accepted; done pulses after the last bit.
// Backpressure: none; start is ignored while busy or during the done cycle.
module seq_gen_10010
  import seq_gen_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 OVL_LEN = DEF_OVL_LEN,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_gen_10010_if.slave bus
);

  // Pattern zero-extended so a 4-bit index is always in range
  localparam logic [15:0] PAT_EXT = 16'(PATTERN);
  localparam logic [3:0]  IDX_TOP = 4'(PAT_LEN - 1);
  localparam logic [3:0]  IDX_RST = OVERLAP ? 4'(PAT_LEN - 1 - OVL_LEN) : IDX_TOP;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rem_q, rem_d;
  logic [3:0] gap_len_q, gap_len_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       done_q, done_d;
  logic       filler;

`ifdef SEQ_GEN_LFSR_EN
  logic lfsr_en;

  // Step on the edge that loads a filler bit into data_out
  assign lfsr_en = (state_d == GAP);

  seq_gen_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .bit_o (filler)
  );
`else
  assign filler = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    gap_len_d    = gap_len_q;
    gap_cnt_d    = gap_cnt_q;
    data_out_d   = 1'b0;
    data_valid_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          rem_d     = bus.count;
          gap_len_d = bus.gap;
          if (bus.count == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d      = SEND;
            idx_d        = IDX_TOP;
            data_out_d   = PAT_EXT[IDX_TOP];
            data_valid_d = 1'b1;
          end
        end
      end

      SEND: begin
        data_valid_d = 1'b1;
        if (idx_q != 4'd0) begin
          idx_d      = idx_q - 4'd1;
          data_out_d = PAT_EXT[idx_q - 4'd1];
        end else begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d      = IDLE;
            data_valid_d = 1'b0;
            done_d       = 1'b1;
          end else if (gap_len_q != 4'd0) begin
            state_d    = GAP;
            gap_cnt_d  = gap_len_q - 4'd1;
            data_out_d = filler;
          end else begin
            idx_d      = IDX_RST;
            data_out_d = PAT_EXT[IDX_RST];
          end
        end
      end

      GAP: begin
        data_valid_d = 1'b1;
        // gap_cnt_q counts filler bits still owed after the one on data_out
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d  = gap_cnt_q - 4'd1;
          data_out_d = filler;
        end else begin
          state_d    = SEND;
          idx_d      = IDX_TOP;
          data_out_d = PAT_EXT[IDX_TOP];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rem_q        <= '0;
      gap_len_q    <= '0;
      gap_cnt_q    <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rem_q        <= rem_d;
      gap_len_q    <= gap_len_d;
      gap_cnt_q    <= gap_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = data_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_gen_10010.sv
// Bench for seq_gen_10010: table of bursts with expected streams, plus restart, reset and count=255 sequences.
module tb_seq_gen_10010;

  logic clk;
  logic rst_n;
  seq_gen_10010_if bus ();

  seq_gen_10010 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    int          gp;
    int          len;
    logic [63:0] bits;
    logic [63:0] mask;
    int          ov;
    int          nov;
  } vec_t;

  vec_t tbl[8];

  int total = 0;
  int bad   = 0;

  bit       exp_q[$];
  bit       exp_done_prev;
  int       vld_cnt, done_cnt;
  bit       prev_vld;
  logic [4:0] m_ovs, m_novs;
  int       m_ovh, m_novh;
  logic [4:0] p_ovs, p_novs;
  int       p_ovh, p_novh;
  logic [7:0] m_lfsr = 8'hA5;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void det_step(input bit b, inout logic [4:0] ovs, inout logic [4:0] novs,
                                   inout int ovh, inout int novh);
    ovs = {ovs[3:0], b};
    if (ovs == 5'b10010) ovh++;
    novs = {novs[3:0], b};
    if (novs == 5'b10010) begin
      novh++;
      novs = '0;
    end
  endfunction

  task automatic lfsr_step(output bit b);
    b = m_lfsr[0];
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[4], m_lfsr[7:1]};
  endtask

  task automatic push_bit(input bit b);
    exp_q.push_back(b);
    det_step(b, p_ovs, p_novs, p_ovh, p_novh);
  endtask

  task automatic push_clear();
    p_ovs = '0; p_novs = '0; p_ovh = 0; p_novh = 0;
  endtask

  task automatic push_bits(input logic [63:0] bits, input logic [63:0] mask, input int len);
    push_clear();
    for (int i = len - 1; i >= 0; i--) begin
      bit b;
      b = bits[i];
`ifdef SEQ_GEN_LFSR_EN
      if (mask[i]) lfsr_step(b);
`endif
      push_bit(b);
    end
  endtask

  // Stream monitor: compares every valid bit against the scoreboard queue
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {bus.data_out, bus.data_valid, bus.busy, bus.done}, 0);
      prev_vld = 1'b0;
    end else begin
      chk("busy_eq_vld", bus.busy, bus.data_valid);
      if (prev_vld && !bus.data_valid) chk("vld_end_done", bus.done, 1);
      if (bus.data_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) chk("extra_bit_qsize", 0, 1 + exp_q.size());
        else chk("bit", bus.data_out, exp_q.pop_front());
        det_step(bus.data_out, m_ovs, m_novs, m_ovh, m_novh);
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_after_vld", prev_vld, exp_done_prev);
        chk("done_vld_low", bus.data_valid, 0);
      end
      prev_vld = bus.data_valid;
    end
  end

  task automatic run_burst(input int cnt, input int gp, input int len, input int ov, input int nov,
                           input int repulse_at);
    int cyc;
    bit seen;
    int eov, enov;
    eov = ov;
    enov = nov;
`ifdef SEQ_GEN_LFSR_EN
    eov = p_ovh;
    enov = p_novh;
`endif
    exp_done_prev = (cnt != 0);
    vld_cnt = 0; done_cnt = 0;
    m_ovs = '0; m_novs = '0; m_ovh = 0; m_novh = 0;
    bus.count = 8'(cnt);
    bus.gap   = 4'(gp);
    bus.start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      bus.start = (cyc == repulse_at);
      if (cyc == repulse_at) begin
        bus.count = 8'd1;
        bus.gap   = 4'd0;
      end
      cyc++;
      if (cnt == 0 && cyc == 1) begin
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
      end
      seen = bus.done;
    end while (!seen && cyc < len + 40);
    if (!seen) chk("done_timeout", cyc, len + 1);
    // start during the done cycle must be ignored
    if (repulse_at >= 0) begin
      bus.count = 8'd1;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("valid_len", vld_cnt, len);
    chk("done_count", done_cnt, 1);
    chk("q_empty", exp_q.size(), 0);
    chk("ovl_hits", m_ovh, eov);
    chk("nonovl_hits", m_novh, enov);
  endtask

  initial begin
    int cyc;
    tbl[0] = '{2, 8, 18, 64'b100100000000010010, 64'b000001111111100000, 2, 2};
    tbl[1] = '{3, 2, 19, 64'b1001000100100010010, 64'b0000011000001100000, 3, 3};
    tbl[2] = '{3, 0, 11, 64'b10010010010, 64'b0, 3, 2};
    tbl[3] = '{0, 3, 0, 64'b0, 64'b0, 0, 0};
    tbl[4] = '{1, 0, 5, 64'b10010, 64'b0, 1, 1};
    tbl[5] = '{2, 1, 11, 64'b10010010010, 64'b00000100000, 3, 2};
    tbl[6] = '{2, 0, 8, 64'b10010010, 64'b0, 2, 1};
    tbl[7] = '{4, 3, 29, 64'b10010000100100001001000010010,
               64'b00000111000001110000011100000, 4, 4};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.count = 8'd0;
    bus.gap = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      push_bits(tbl[r].bits, tbl[r].mask, tbl[r].len);
      run_burst(tbl[r].cnt, tbl[r].gp, tbl[r].len, tbl[r].ov, tbl[r].nov, -1);
    end

    // start re-pulsed mid-burst with other count/gap, and again in the done cycle
    push_bits(tbl[1].bits, tbl[1].mask, tbl[1].len);
    run_burst(3, 2, 19, 3, 3, 6);

    // async reset during the second occurrence
    push_bits(tbl[1].bits, tbl[1].mask, tbl[1].len);
    vld_cnt = 0;
    exp_done_prev = 1'b1;
    bus.count = 8'd3;
    bus.gap = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (vld_cnt < 9 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("pre_reset_bits", vld_cnt, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_data_out", bus.data_out, 0);
    chk("async_data_valid", bus.data_valid, 0);
    chk("async_busy", bus.busy, 0);
    exp_q.delete();
    m_lfsr = 8'hA5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", bus.data_valid, 0);
    push_bits(tbl[1].bits, tbl[1].mask, tbl[1].len);
    run_burst(3, 2, 19, 3, 3, -1);

    // count=255 back-to-back with overlap: 5 + 254*3 bits
    push_clear();
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
    for (int k = 0; k < 254; k++) begin
      push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
    end
    run_burst(255, 0, 767, 255, 128, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
